// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 16-bit accumulator-style processor control path.
//
// Contents:
//   - opcode constants (IR[15:12])
//   - sequencer state enum: FETCH, DECODE, EXECUTE, WRITEBACK (2-bit)
//   - ALU operation encodings
//   - instruction field bit positions
//   - control bundle produced by instr_decoder
// -----------------------------------------------------------------------------
package proc_pkg;

    // Opcodes. Anything not listed here executes as a NOP.
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    // Instruction field bit positions.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 8;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'b00,
        ST_DECODE    = 2'b01,
        ST_EXECUTE   = 2'b10,
        ST_WRITEBACK = 2'b11
    } seq_state_t;

    typedef enum logic [1:0] {
        ALU_PASS_B   = 2'b00,
        ALU_ADD      = 2'b01,
        ALU_SUB      = 2'b10,
        ALU_PASS_IMM = 2'b11
    } alu_op_t;

    // Control bundle decoded from the instruction register.
    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_use_imm;
        logic    writes_reg;
        logic    is_out;
        logic    is_jmp;
        logic    is_br;
    } ctrl_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of the instruction register into the control
// bundle used by program_sequencer.
//
// Ports:
//   ir    in   16        instruction register
//   ctrl  out  ctrl_t    alu_op, alu_use_imm, writes_reg, is_out, is_jmp, is_br
// -----------------------------------------------------------------------------
module instr_decoder
    import proc_pkg::*;
(
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl             = '0;
        ctrl.alu_op      = ALU_PASS_B;
        unique case (opcode_of(ir))
            OP_LOAD: begin
                ctrl.alu_op      = ALU_PASS_IMM;
                ctrl.alu_use_imm = 1'b1;
                ctrl.writes_reg  = 1'b1;
            end
            OP_ADD: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.writes_reg = 1'b1;
            end
            OP_SUB: begin
                ctrl.alu_op     = ALU_SUB;
                ctrl.writes_reg = 1'b1;
            end
            OP_SUBI: begin
                ctrl.alu_op      = ALU_SUB;
                ctrl.alu_use_imm = 1'b1;
                ctrl.writes_reg  = 1'b1;
            end
            OP_MOV: begin
                ctrl.alu_op     = ALU_PASS_B;
                ctrl.writes_reg = 1'b1;
            end
            OP_JMP:  ctrl.is_jmp = 1'b1;
            OP_BR:   ctrl.is_br  = 1'b1;
            OP_OUT:  ctrl.is_out = 1'b1;
            default: ;  // NOP: no strobes, PC+1
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Control unit for the 16-bit accumulator processor. Owns PC, IR and the zero
// flag, fetches from the combinational program ROM and drives the register
// file, ALU and output-port controls. Every instruction runs through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK.
//
// Parameters:
//   PC_W    program counter / ROM address width (ROM depth 2^PC_W)
//   RST_PC  PC value after reset
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   step              (only with SEQ_SINGLE_STEP_EN) single-step request
//   run               allows leaving FETCH
//   rom_addr/rom_data ROM address (= PC) and returned instruction word
//   rf_raddr_a/b      register read addresses (IR[11:9], IR[8:6])
//   alu_op, alu_use_imm, imm   ALU controls and immediate IR[7:0]
//   alu_zero          ALU result is zero (sampled in EXECUTE)
//   rf_we, rf_waddr   register write strobe / address (WRITEBACK only)
//   out_we            output-port load strobe (WRITEBACK only)
//   pc, zflag         debug view of PC and stored zero flag
//   state_dbg         debug view of the FSM state
//
// Configuration macro: SEQ_SINGLE_STEP_EN
//   Defined   -> FETCH advances only on run=1 plus a rising edge of step.
//   Undefined -> no step port; run alone gates FETCH.
// -----------------------------------------------------------------------------
module program_sequencer
    import proc_pkg::*;
#(
    parameter int          PC_W   = 4,
    parameter int unsigned RST_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    output logic [2:0]      rf_raddr_a,
    output logic [2:0]      rf_raddr_b,
    output logic [1:0]      alu_op,
    output logic            alu_use_imm,
    output logic [7:0]      imm,
    input  logic            alu_zero,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic            out_we,
    output logic [PC_W-1:0] pc,
    output logic            zflag,
    output logic [1:0]      state_dbg
);

    seq_state_t      state, state_nxt;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc_q;
    logic            zflag_q;
    ctrl_t           ctrl;
    logic            fetch_go;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;

    // -------------------------------------------------------------------------
    // FETCH gating
    // -------------------------------------------------------------------------
`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end

    // One instruction per rising edge of step; the edge is only consumed
    // when it lands while the sequencer is waiting in FETCH.
    assign fetch_go = run & step & ~step_q;
`else
    assign fetch_go = run;
`endif

    // -------------------------------------------------------------------------
    // Decode (from registered IR only, never from rom_data)
    // -------------------------------------------------------------------------
    instr_decoder u_decoder (
        .ir   (ir),
        .ctrl (ctrl)
    );

    // Targets are 4 bits in the encoding; the cast zero-extends or truncates
    // to the PC width.
    assign target = PC_W'(ir[TGT_MSB:TGT_LSB]);
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        pc_nxt = pc_inc;
        if (ctrl.is_jmp)                 pc_nxt = target;
        else if (ctrl.is_br && zflag_q)  pc_nxt = target;
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FETCH:     if (fetch_go) state_nxt = ST_DECODE;
            ST_DECODE:    state_nxt = ST_EXECUTE;
            ST_EXECUTE:   state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: state_nxt = ST_FETCH;
            default:      state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Architectural registers: IR, PC, zero flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            pc_q    <= PC_W'(RST_PC);
            zflag_q <= 1'b0;
        end else begin
            if (state == ST_FETCH && fetch_go)
                ir <= rom_data;
            // Only register-writing ops refresh the flag, so BR always sees
            // the result of the most recent register write.
            if (state == ST_EXECUTE && ctrl.writes_reg)
                zflag_q <= alu_zero;
            if (state == ST_WRITEBACK)
                pc_q <= pc_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // IR resets to a NOP word, so all IR-derived controls read as 0 in reset
    // and hold steady from DECODE until the next FETCH edge.
    assign rom_addr    = pc_q;
    assign rf_raddr_a  = ir[RD_MSB:RD_LSB];
    assign rf_raddr_b  = ir[RS_MSB:RS_LSB];
    assign rf_waddr    = ir[RD_MSB:RD_LSB];
    assign imm         = ir[IMM_MSB:IMM_LSB];
    assign alu_op      = ctrl.alu_op;
    assign alu_use_imm = ctrl.alu_use_imm;

    // Strobes depend on the async-reset state register, so they drop the
    // instant rst_n goes low.
    assign rf_we  = (state == ST_WRITEBACK) && ctrl.writes_reg;
    assign out_we = (state == ST_WRITEBACK) && ctrl.is_out;

    assign pc        = pc_q;
    assign zflag     = zflag_q;
    assign state_dbg = state;

endmodule
